// File: rtl/alu_result_collector.sv
// TinyALU pin monitor: pairs each started command with its done result, measures latency,
// flags timeouts/protocol errors and buffers completed records in a show-ahead FIFO.
module alu_result_collector #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               A,
  input  logic [7:0]               B,
  input  logic [2:0]               op,
  input  logic                     start,
  input  logic                     done,
  input  logic [15:0]              result,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [7:0]               rec_a,
  output logic [7:0]               rec_b,
  output logic [2:0]               rec_op,
  output logic [15:0]              rec_result,
  output logic [7:0]               rec_latency,
  output logic                     rec_timeout,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [7:0]               overflow_cnt,
  output logic                     proto_err,
  output logic                     busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [15:0] result;
    logic [7:0]  latency;
    logic        timeout;
  } rec_t;

  typedef enum logic [1:0] {IDLE, WAIT, PUSH} state_t;

  state_t          state_q, state_d;
  rec_t            cur_q, cur_d;
  logic            start_q;
  logic            proto_q, proto_d;
  logic [7:0]      ovf_q, ovf_d;
  rec_t            mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;

  logic start_edge_c, full_c, pop_c, push_c;

  assign start_edge_c = start & ~start_q;
  assign full_c       = (count_q == CW'(DEPTH));
  assign pop_c        = rec_valid & rec_ready;
  // A full FIFO can still take the record when the head leaves in the same cycle.
  assign push_c       = (state_q == PUSH) && (!full_c || pop_c);

  // Command capture / latency measurement FSM.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    proto_d = proto_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (done) proto_d = 1'b1;
        if (start_edge_c && op != 3'd0) begin
          cur_d.a       = A;
          cur_d.b       = B;
          cur_d.op      = op;
          cur_d.latency = 8'd0;
          state_d       = WAIT;
        end
      end
      WAIT: begin
        cur_d.latency = cur_q.latency + 8'd1;
        if (start_edge_c) proto_d = 1'b1;
        if (done) begin
          cur_d.result  = result;
          cur_d.timeout = 1'b0;
          state_d       = PUSH;
        end else if (cur_d.latency == 8'(TIMEOUT)) begin
          cur_d.result  = 16'd0;
          cur_d.timeout = 1'b1;
          state_d       = PUSH;
        end
      end
      PUSH: begin
        if (start_edge_c) proto_d = 1'b1;
        if (!push_c && ovf_q != 8'hFF) ovf_d = ovf_q + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign count_d = count_q + CW'(push_c) - CW'(pop_c);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      start_q  <= 1'b0;
      proto_q  <= 1'b0;
      ovf_q    <= 8'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      start_q <= start;
      proto_q <= proto_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
      if (push_c) begin
        mem_q[wr_ptr_q] <= cur_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  assign rec_valid    = (count_q != '0);
  assign rec_a        = mem_q[rd_ptr_q].a;
  assign rec_b        = mem_q[rd_ptr_q].b;
  assign rec_op       = mem_q[rd_ptr_q].op;
  assign rec_result   = mem_q[rd_ptr_q].result;
  assign rec_latency  = mem_q[rd_ptr_q].latency;
  assign rec_timeout  = mem_q[rd_ptr_q].timeout;
  assign fifo_count   = count_q;
  assign overflow_cnt = ovf_q;
  assign proto_err    = proto_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_alu_result_collector.sv
// Scoreboard bench for alu_result_collector: directed commands push expected records,
// a monitor pops and compares each record as it is handed off.
module tb_alu_result_collector;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  A, B;
  logic [2:0]  op;
  logic        start, done;
  logic [15:0] result;
  logic        rec_valid, rec_ready;
  logic [7:0]  rec_a, rec_b;
  logic [2:0]  rec_op;
  logic [15:0] rec_result;
  logic [7:0]  rec_latency;
  logic        rec_timeout;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [7:0]  overflow_cnt;
  logic        proto_err, busy;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [2:0]  op;
    logic [15:0] result;
    logic [7:0]  latency;
    logic        timeout;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  alu_result_collector #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start), .done(done),
    .result(result), .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_a(rec_a),
    .rec_b(rec_b), .rec_op(rec_op), .rec_result(rec_result), .rec_latency(rec_latency),
    .rec_timeout(rec_timeout), .fifo_count(fifo_count), .overflow_cnt(overflow_cnt),
    .proto_err(proto_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: handshake decided at the coming posedge; inputs only change just after posedges.
  initial begin
    exp_t e, g;
    forever begin
      @(negedge clk);
      if (rec_valid && rec_ready && !reset) begin
        g = '{rec_a, rec_b, rec_op, rec_result, rec_latency, rec_timeout};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_record: got %h expected none", g);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            n_bad++;
            $display("FAIL record: got %h expected %h", g, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a command; done is sampled d cycles after the start edge. Ends in the PUSH cycle.
  task automatic cmd(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                     input int d, input logic [15:0] r);
    A = a; B = b; op = o; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (d - 1) tick();
    done = 1'b1; result = r;
    tick();
    done = 1'b0;
  endtask

  task automatic cmd_full(input logic [7:0] a, input logic [7:0] b, input logic [2:0] o,
                          input int d, input logic [15:0] r);
    cmd(a, b, o, d, r);
    tick();
  endtask

  task automatic drain(input string name);
    int t;
    rec_ready = 1'b1;
    t = 0;
    while ((fifo_count != 0 || exp_q.size() != 0) && t < 60) begin
      tick();
      t++;
    end
    check({name, "_drain_count"}, int'(fifo_count), 0);
    check({name, "_drain_queue"}, exp_q.size(), 0);
    rec_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; A = '0; B = '0; op = '0; start = 1'b0; done = 1'b0;
    result = '0; rec_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    check("rst_valid", rec_valid, 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_ovf", overflow_cnt, 0);
    check("rst_proto", proto_err, 0);
    check("rst_busy", busy, 0);

    // 1: ADD with latency 1, record visible 2 cycles after done
    exp_q.push_back('{8'h12, 8'h34, 3'd1, 16'h0046, 8'd1, 1'b0});
    cmd(8'h12, 8'h34, 3'd1, 1, 16'h0046);
    check("add_push_busy", busy, 1);
    check("add_push_valid", rec_valid, 0);
    tick();
    check("add_valid", rec_valid, 1);
    check("add_count", int'(fifo_count), 1);
    check("add_busy_done", busy, 0);
    drain("add");

    // 2: MUL latency 3, then a no_op start that must not record
    exp_q.push_back('{8'hFF, 8'hFF, 3'd4, 16'hFE01, 8'd3, 1'b0});
    cmd_full(8'hFF, 8'hFF, 3'd4, 3, 16'hFE01);
    check("mul_count", int'(fifo_count), 1);
    A = 8'h55; B = 8'h66; op = 3'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("noop_busy", busy, 0);
    tick(); tick();
    check("noop_count", int'(fifo_count), 1);
    drain("mul");

    // 3: timeout
    exp_q.push_back('{8'h07, 8'h09, 3'd2, 16'h0000, 8'(TIMEOUT), 1'b1});
    A = 8'h07; B = 8'h09; op = 3'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("to_busy", busy, 1);
    repeat (TIMEOUT) tick();
    check("to_push_busy", busy, 1);
    check("to_push_valid", rec_valid, 0);
    tick();
    check("to_busy_drop", busy, 0);
    check("to_valid", rec_valid, 1);
    drain("to");

    // 4: overflow with consumer stalled, then in-order drain
    for (int i = 0; i < DEPTH + 3; i++) begin
      if (i < DEPTH)
        exp_q.push_back('{8'(i + 1), 8'(i + 16), 3'd1, 16'(2 * i + 17), 8'd1, 1'b0});
      cmd_full(8'(i + 1), 8'(i + 16), 3'd1, 1, 16'(2 * i + 17));
    end
    check("ovf_count", int'(fifo_count), DEPTH);
    check("ovf_cnt", overflow_cnt, 3);
    check("ovf_proto_clean", proto_err, 0);
    drain("ovf");

    // 5a: done while idle
    do_reset();
    done = 1'b1;
    tick();
    done = 1'b0;
    check("proto_idle_done", proto_err, 1);
    tick();
    check("proto_sticky", proto_err, 1);
    // 5b: second start edge during WAIT
    do_reset();
    check("proto_cleared", proto_err, 0);
    exp_q.push_back('{8'h21, 8'h03, 3'd1, 16'h0024, 8'd3, 1'b0});
    A = 8'h21; B = 8'h03; op = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    A = 8'h99; B = 8'h77; op = 3'd3; start = 1'b1;
    tick();
    start = 1'b0; done = 1'b1; result = 16'h0024;
    tick();
    done = 1'b0;
    tick(); tick();
    check("proto_wait_start", proto_err, 1);
    check("proto_one_record", int'(fifo_count), 1);
    drain("proto");

    // 6: reset mid-command with buffered records and error state
    cmd_full(8'h01, 8'h02, 3'd1, 1, 16'h0003);
    cmd_full(8'h04, 8'h05, 3'd1, 1, 16'h0009);
    check("mid_count", int'(fifo_count), 2);
    A = 8'h0A; B = 8'h0B; op = 3'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("mid_busy", busy, 1);
    check("mid_proto_set", proto_err, 1);
    do_reset();
    exp_q.delete();
    check("mid_valid", rec_valid, 0);
    check("mid_busy_clr", busy, 0);
    check("mid_count_clr", int'(fifo_count), 0);
    check("mid_ovf_clr", overflow_cnt, 0);
    check("mid_proto_clr", proto_err, 0);
    exp_q.push_back('{8'h30, 8'h40, 3'd1, 16'h0070, 8'd2, 1'b0});
    cmd_full(8'h30, 8'h40, 3'd1, 2, 16'h0070);
    check("post_rst_count", int'(fifo_count), 1);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
